inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 77 +++++++
 tb/tb_inst_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst} pairs.
// Define INST_QUEUE_BYTESWAP_EN to byte-reverse instruction words on push.
module inst_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NB = INST_W / 8;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [INST_W-1:0] inst_wr;
  logic push, pop;

  // in_ready depends only on registered count, so a pop never frees a slot same-cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign out_pc   = out_valid ? pc_mem[head_q]   : '0;
  assign out_inst = out_valid ? inst_mem[head_q] : '0;

`ifdef INST_QUEUE_BYTESWAP_EN
  // Fetched words are little-endian: byte 0 lands in the most significant byte.
  always_comb begin
    inst_wr = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      inst_wr[8*(NB-1-b) +: 8] = in_inst[8*b +: 8];
    end
  end
`else
  assign inst_wr = in_inst;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      pc_mem[tail_q]   <= in_pc;
      inst_mem[tail_q] <= inst_wr;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key scenarios.
module tb_inst_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready, out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [2:0]        count;

  int errors = 0;
  int checks = 0;

  logic [63:0] mq[$];

  inst_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef INST_QUEUE_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs held across the edge, then compare.
  task automatic step();
    bit m_push, m_pop;
    logic [63:0] hd;
    m_push = in_valid && (mq.size() < DEPTH);
    m_pop  = (mq.size() != 0) && out_ready;
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back({in_pc, stored(in_inst)});
    end
    #1;
    hd = (mq.size() != 0) ? mq[0] : 64'd0;
    check("model.out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("model.out_pc",    64'(out_pc),    64'(hd[63:32]));
    check("model.out_inst",  64'(out_inst),  64'(hd[31:0]));
    check("model.count",     64'(count),     64'(mq.size()));
    check("model.in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    step();
    in_valid = 1'b0; in_pc = 32'hdead_beef; in_inst = 32'hfeed_face;
  endtask

  initial begin
    logic [31:0] exp_inst;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    step(); step();
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.count",     64'(count),     64'd0);
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.out_pc",    64'(out_pc),    64'd0);
    check("reset.out_inst",  64'(out_inst),  64'd0);

    // First push, visible one cycle later
    push1(32'h100, 32'h1122_3344);
`ifdef INST_QUEUE_BYTESWAP_EN
    exp_inst = 32'h4433_2211;
`else
    exp_inst = 32'h1122_3344;
`endif
    check("first.out_valid", 64'(out_valid), 64'd1);
    check("first.out_pc",    64'(out_pc),    64'h100);
    check("first.out_inst",  64'(out_inst),  64'(exp_inst));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fill to full; the 5th offer is refused
    for (int i = 0; i < 4; i++) push1(32'h200 + 32'(4*i), 32'ha000 + 32'(i));
    check("full.count",    64'(count),    64'd4);
    check("full.in_ready", 64'(in_ready), 64'd0);
    push1(32'h300, 32'hbbbb);
    check("full.count5", 64'(count), 64'd4);
    // Pop while also offering: full queue must not accept the offer
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.pc", 64'(out_pc), 64'(32'h200 + 32'(4*i)));
      if (i == 0) begin in_valid = 1'b1; in_pc = 32'h333; in_inst = 32'h3; end
      step();
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("drain.out_valid", 64'(out_valid), 64'd0);
    check("drain.out_pc",    64'(out_pc),    64'd0);

    // Steady push+pop at count 2, pointers wrap
    push1(32'h400, 32'h0); push1(32'h404, 32'h1);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("stream.head", 64'(out_pc), 64'(32'h400 + 32'(4*k)));
      in_pc = 32'h408 + 32'(4*k); in_inst = 32'(k + 2);
      step();
      check("stream.count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    check("stream.empty", 64'(count), 64'd0);

    // Flush beats same-cycle push and pop
    for (int i = 0; i < 3; i++) push1(32'h500 + 32'(4*i), 32'(i));
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h5ff; in_inst = 32'h55;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush.count",     64'(count),     64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    step();
    check("flush.absent", 64'(out_valid), 64'd0);

    // Reset beats flush and push
    push1(32'h600, 32'h1); push1(32'h604, 32'h2);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h6ff; in_inst = 32'h66;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst.count",    64'(count),    64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_pc",   64'(out_pc),   64'd0);
    push1(32'h700, 32'h77);
    check("rst.after_pc", 64'(out_pc), 64'h700);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Stall hold
    push1(32'h800, 32'h8888_0000); push1(32'h804, 32'h8888_0001);
    for (int i = 0; i < 5; i++) begin
      in_pc = 32'(i); in_inst = 32'(i);
      step();
      check("stall.out_valid", 64'(out_valid), 64'd1);
      check("stall.out_pc",    64'(out_pc),    64'h800);
      check("stall.out_inst",  64'(out_inst),  64'(stored(32'h8888_0000)));
      check("stall.count",     64'(count),     64'd2);
    end

    // Mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
